// File: rtl/ctrl_pkg.sv
// Shared decode constants, state encoding and opcode helpers for the
// instruction sequencer.
package ctrl_pkg;

    localparam logic [2:0] OP_HLT = 3'd0;
    localparam logic [2:0] OP_SKZ = 3'd1;
    localparam logic [2:0] OP_ADD = 3'd2;
    localparam logic [2:0] OP_AND = 3'd3;
    localparam logic [2:0] OP_XOR = 3'd4;
    localparam logic [2:0] OP_LDA = 3'd5;
    localparam logic [2:0] OP_STO = 3'd6;
    localparam logic [2:0] OP_JMP = 3'd7;

    typedef enum logic [3:0] {
        ST_P0     = 4'd0,
        ST_P1     = 4'd1,
        ST_P2     = 4'd2,
        ST_P3     = 4'd3,
        ST_P4     = 4'd4,
        ST_P5     = 4'd5,
        ST_P6     = 4'd6,
        ST_P7     = 4'd7,
        ST_HALTED = 4'd8
    } state_e;

    function automatic logic is_alu_op(input logic [2:0] op);
        return (op == OP_ADD) || (op == OP_AND) || (op == OP_XOR) || (op == OP_LDA);
    endfunction

    // Caller passes the opcode zero-extended to 32 bits; any bit above [2:0] is illegal.
    function automatic logic is_ill_op(input logic [31:0] op);
        return (op[31:3] != 29'd0);
    endfunction

endpackage

// File: rtl/ctrl_stall_tmr.sv
// Stall timeout counter: counts stalled cycles and flags expiry when the
// counter sits at its all-ones limit while still stalled.
module ctrl_stall_tmr
    import ctrl_pkg::*;
#(
    parameter int TO_W = 4
) (
    input  logic clk,
    input  logic rst_,
    input  logic clr,
    input  logic stall,
    output logic expire
);

    logic [TO_W-1:0] r_cnt;

    assign expire = stall && (r_cnt == {TO_W{1'b1}});

    // Stall cycle counter, cleared whenever the sequencer changes state.
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            r_cnt <= '0;
        end else if (clr) begin
            r_cnt <= '0;
        end else if (stall) begin
            r_cnt <= r_cnt + {{(TO_W-1){1'b0}}, 1'b1};
        end else begin
            r_cnt <= r_cnt;
        end
    end

endmodule

// File: rtl/ctrl_seq_p.sv
// Eight-phase instruction sequencer with memory stalls, stall timeout,
// latched HALTED state and sticky faults. CTRL_STEP_EN adds single-step input.
module ctrl_seq_p
    import ctrl_pkg::*;
#(
    parameter int OPW  = 3,
    parameter int TO_W = 4
) (
    input  logic           clk,
    input  logic           rst_,
    input  logic [OPW-1:0] opcode,
    input  logic           zero,
    input  logic           mem_rdy,
    input  logic           run,
`ifdef CTRL_STEP_EN
    input  logic           step,
`endif
    output logic           sel,
    output logic           rd,
    output logic           wr,
    output logic           ld_ir,
    output logic           ld_ac,
    output logic           ld_pc,
    output logic           inc_pc,
    output logic           halt,
    output logic           data_e,
    output logic [3:0]     state,
    output logic           bus_err,
    output logic           ill_op
);

    state_e     r_state;
    logic       r_bus_err;
    logic       r_ill_op;
    logic [2:0] w_op;
    logic       w_alu;
    logic       w_ill;
    logic       w_skz;
    logic       w_jmp;
    logic       w_sto;
    logic       w_stall;
    logic       w_adv;
    logic       w_expire;
    logic       w_tmr_clr;
    logic       w_step;

    assign w_op   = opcode[2:0];
    assign w_alu  = is_alu_op(w_op);
    assign w_ill  = is_ill_op(32'(opcode));
    assign w_skz  = (w_op == OP_SKZ);
    assign w_jmp  = (w_op == OP_JMP);
    assign w_sto  = (w_op == OP_STO);

`ifdef CTRL_STEP_EN
    assign w_step = step;
`else
    assign w_step = 1'b0;
`endif

    // Phases that wait on memory, and whether this cycle moves on.
    always_comb begin
        w_stall = 1'b0;
        case (r_state)
            ST_P2:   w_stall = !mem_rdy;
            ST_P6:   w_stall = w_alu && !mem_rdy;
            ST_P7:   w_stall = w_sto && !mem_rdy;
            default: w_stall = 1'b0;
        endcase
    end

    assign w_adv     = !w_stall;
    assign w_tmr_clr = !w_stall || w_expire;

    ctrl_stall_tmr #(
        .TO_W (TO_W)
    ) u_tmr (
        .clk    (clk),
        .rst_   (rst_),
        .clr    (w_tmr_clr),
        .stall  (w_stall),
        .expire (w_expire)
    );

    // Datapath controls; commit strobes are gated by w_adv so a stall never repeats them.
    always_comb begin
        sel    = 1'b0;
        rd     = 1'b0;
        wr     = 1'b0;
        ld_ir  = 1'b0;
        ld_ac  = 1'b0;
        ld_pc  = 1'b0;
        inc_pc = 1'b0;
        halt   = 1'b0;
        data_e = 1'b0;
        case (r_state)
            ST_P0: sel = 1'b1;
            ST_P1: begin
                sel = 1'b1;
                rd  = 1'b1;
            end
            ST_P2: begin
                sel   = 1'b1;
                rd    = 1'b1;
                ld_ir = w_adv;
            end
            ST_P3: begin
                sel   = 1'b1;
                rd    = 1'b1;
                ld_ir = 1'b1;
            end
            ST_P4: inc_pc = 1'b1;
            ST_P5: rd = w_alu;
            ST_P6: begin
                rd     = w_alu;
                data_e = !w_alu;
                inc_pc = w_skz && zero && w_adv;
                ld_pc  = w_jmp && w_adv;
            end
            ST_P7: begin
                rd     = w_alu;
                data_e = !w_alu;
                wr     = w_sto;
                ld_ac  = w_alu && w_adv;
                inc_pc = ((w_skz && zero) || w_jmp) && w_adv;
                ld_pc  = w_jmp && w_adv;
            end
            ST_HALTED: halt = 1'b1;
            default: begin
                sel = 1'b0;
            end
        endcase
    end

    // Sequencer state and sticky fault flags.
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            r_state   <= ST_P0;
            r_bus_err <= 1'b0;
            r_ill_op  <= 1'b0;
        end else begin
            case (r_state)
                ST_P0: r_state <= ST_P1;
                ST_P1: r_state <= ST_P2;
                ST_P2: begin
                    if (w_expire) begin
                        r_state   <= ST_HALTED;
                        r_bus_err <= 1'b1;
                    end else if (w_adv) begin
                        r_state <= ST_P3;
                    end else begin
                        r_state <= r_state;
                    end
                end
                ST_P3: r_state <= ST_P4;
                ST_P4: begin
                    if (w_ill) begin
                        r_state  <= ST_HALTED;
                        r_ill_op <= 1'b1;
                    end else if (w_op == OP_HLT) begin
                        r_state <= ST_HALTED;
                    end else begin
                        r_state <= ST_P5;
                    end
                end
                ST_P5: r_state <= ST_P6;
                ST_P6: begin
                    if (w_expire) begin
                        r_state   <= ST_HALTED;
                        r_bus_err <= 1'b1;
                    end else if (w_adv) begin
                        r_state <= ST_P7;
                    end else begin
                        r_state <= r_state;
                    end
                end
                ST_P7: begin
                    if (w_expire) begin
                        r_state   <= ST_HALTED;
                        r_bus_err <= 1'b1;
                    end else if (w_adv) begin
                        r_state <= w_step ? ST_HALTED : ST_P0;
                    end else begin
                        r_state <= r_state;
                    end
                end
                ST_HALTED: begin
                    if (run) begin
                        r_state   <= ST_P0;
                        r_bus_err <= 1'b0;
                        r_ill_op  <= 1'b0;
                    end else begin
                        r_state <= r_state;
                    end
                end
                default: r_state <= ST_P0;
            endcase
        end
    end

    assign state   = r_state;
    assign bus_err = r_bus_err;
    assign ill_op  = r_ill_op;

endmodule
